// File: rtl/ram_frame_wr_ctrl_pkg.sv
// Shared types and default command bytes for the layered pixel RAM write controller.
package ram_frame_wr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_WR_PTR  = 2'd2
    } wr_state_e;

    localparam logic [7:0] CMD_DATA_DEF = 8'hDA;
    localparam logic [7:0] CMD_PTR_DEF  = 8'hCC;

endpackage

// File: rtl/ram_frame_wr_ctrl_if.sv
// Byte-strobe input side and RAM write side of the frame write controller.
interface ram_frame_wr_ctrl_if
    import ram_frame_wr_ctrl_pkg::*;
#(
    parameter int LAYERS = 8,
    parameter int ADDR_W = 6,
    parameter int BPP    = 3
) ();

    // Handshake: write is a single-cycle strobe with no backpressure. A byte is
    // taken on the SCLK edge where write=1 and trans=0; a strobe seen while
    // trans=1 is discarded. RAM enables are valid only in that accepting cycle.
    logic              write;
    logic              DC;
    logic              trans;
    logic [7:0]        SHIFT_REG;
    logic [LAYERS-1:0] layer_en;
    logic [ADDR_W-1:0] wraddre;
    logic [BPP:0]      byte_en;
    logic              read;
    logic              busy;
    logic              abort;
    wr_state_e         state;

    modport master (
        output write, DC, trans, SHIFT_REG,
        input  layer_en, wraddre, byte_en, read, busy, abort, state
    );

    modport slave (
        input  write, DC, trans, SHIFT_REG,
        output layer_en, wraddre, byte_en, read, busy, abort, state
    );

endinterface

// File: rtl/ram_frame_wr_ctrl_ram_addr_map.sv
// Pixel index to RAM address; optional serpentine reverses columns on odd rows.
module ram_addr_map #(
    parameter int ADDR_W     = 6,
    parameter int ROW_LEN    = 8,
    parameter int SERPENTINE = 0
) (
    input  logic [ADDR_W-1:0] pixel,
    output logic [ADDR_W-1:0] addr
);

    localparam int CB = $clog2(ROW_LEN);

    generate
        if (SERPENTINE != 0 && CB > 0 && CB < ADDR_W) begin : g_serp
            // ROW_LEN is a power of two, so ROW_LEN-1-col is the bitwise inverse of col.
            always_comb begin
                addr = pixel;
                if (pixel[CB]) begin
                    addr[CB-1:0] = ~pixel[CB-1:0];
                end
            end
        end else begin : g_linear
            assign addr = pixel;
        end
    endgenerate

endmodule

// File: rtl/ram_frame_wr_ctrl.sv
// Decodes command bytes and steers data bytes into per-layer RAM write enables,
// addresses and byte lanes; pulses read when a full data frame has been written.
module ram_frame_wr_ctrl
    import ram_frame_wr_ctrl_pkg::*;
#(
    parameter int         LAYERS     = 8,
    parameter int         ADDR_W     = 6,
    parameter int         BPP        = 3,
    parameter int         ROW_LEN    = 8,
    parameter int         SERPENTINE = 0,
    parameter logic [7:0] CMD_DATA   = CMD_DATA_DEF,
    parameter logic [7:0] CMD_PTR    = CMD_PTR_DEF
) (
    input  logic                SCLK,
    input  logic                Rst_n,
    ram_frame_wr_ctrl_if.slave  bus
);

    localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam int NW = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int BW = BPP + 1;

    localparam logic [LW-1:0]     LAYER_MAX = LW'(LAYERS - 1);
    localparam logic [NW-1:0]     LANE_TOP  = NW'(BPP - 1);
    localparam logic [ADDR_W-1:0] PIX_MAX   = '1;
    localparam logic [BW-1:0]     PTR_LANE  = BW'(1) << BPP;

    wr_state_e         state_q, state_d;
    logic [LW-1:0]     layer_q, layer_d;
    logic [ADDR_W-1:0] pixel_q, pixel_d;
    logic [NW-1:0]     lane_q, lane_d;
    logic              read_q, read_d;
    logic              abort_q, abort_d;
    logic [LAYERS-1:0] layer_en_c;
    logic [BW-1:0]     byte_en_c;

    logic accept, data_stb, cmd_stb;
    assign accept   = bus.write && !bus.trans;
    assign data_stb = accept && bus.DC;
    assign cmd_stb  = accept && !bus.DC;

    always_ff @(posedge SCLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            pixel_q <= '0;
            lane_q  <= LANE_TOP;
            read_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            pixel_q <= pixel_d;
            lane_q  <= lane_d;
            read_q  <= read_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        pixel_d    = pixel_q;
        lane_d     = lane_q;
        read_d     = 1'b0;
        abort_d    = 1'b0;
        layer_en_c = '0;
        byte_en_c  = '0;

        if (cmd_stb) begin
            // Any command restarts from zero; interrupting a frame flags abort.
            abort_d = (state_q != ST_IDLE);
            layer_d = '0;
            pixel_d = '0;
            lane_d  = LANE_TOP;
            if (bus.SHIFT_REG == CMD_DATA) begin
                state_d = ST_WR_DATA;
            end else if (bus.SHIFT_REG == CMD_PTR) begin
                state_d = ST_WR_PTR;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (data_stb) begin
            case (state_q)
                ST_WR_DATA: begin
                    layer_en_c = LAYERS'(1) << layer_q;
                    byte_en_c  = BW'(1) << lane_q;
                    if (lane_q != '0) begin
                        lane_d = lane_q - 1'b1;
                    end else begin
                        lane_d = LANE_TOP;
                        if (pixel_q != PIX_MAX) begin
                            pixel_d = pixel_q + 1'b1;
                        end else begin
                            pixel_d = '0;
                            if (layer_q != LAYER_MAX) begin
                                layer_d = layer_q + 1'b1;
                            end else begin
                                layer_d = '0;
                                state_d = ST_IDLE;
                                read_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_WR_PTR: begin
                    layer_en_c = '1;
                    byte_en_c  = PTR_LANE;
                    if (pixel_q != PIX_MAX) begin
                        pixel_d = pixel_q + 1'b1;
                    end else begin
                        pixel_d = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    ram_addr_map #(
        .ADDR_W     (ADDR_W),
        .ROW_LEN    (ROW_LEN),
        .SERPENTINE (SERPENTINE)
    ) u_addr_map (
        .pixel (pixel_q),
        .addr  (bus.wraddre)
    );

    assign bus.layer_en = layer_en_c;
    assign bus.byte_en  = byte_en_c;
    assign bus.read     = read_q;
    assign bus.abort    = abort_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.state    = state_q;

endmodule

// File: tb/tb_ram_frame_wr_ctrl.sv
// Randomised byte-strobe stimulus for linear and serpentine controllers, checked
// every cycle against a frame-position model plus a few literal expectations.
module tb_ram_frame_wr_ctrl;

    localparam int LAYERS = 8;
    localparam int ADDR_W = 6;
    localparam int BPP    = 3;
    localparam int NPIX   = 1 << ADDR_W;
    localparam int FRAME  = LAYERS * NPIX * BPP;

    localparam int M_IDLE = 0;
    localparam int M_DATA = 1;
    localparam int M_PTR  = 2;

    logic       SCLK = 1'b0;
    logic       Rst_n;
    logic       write;
    logic       DC;
    logic       trans;
    logic [7:0] SHIFT_REG;

    int n_pass  = 0;
    int n_total = 0;

    // Model: frame mode and count of bytes accepted so far in the frame.
    int         m_mode = M_IDLE;
    int         m_k    = 0;
    logic [1:0] exp_q[$];   // {read, abort} expected in the following cycle

    // clock / reset
    always #5 SCLK = ~SCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got=timeout exp=finish");
        $fatal(1);
    end

    ram_frame_wr_ctrl_if #(.LAYERS(LAYERS), .ADDR_W(ADDR_W), .BPP(BPP)) bus_a ();
    ram_frame_wr_ctrl_if #(.LAYERS(LAYERS), .ADDR_W(ADDR_W), .BPP(BPP)) bus_s ();

    assign bus_a.write     = write;
    assign bus_a.DC        = DC;
    assign bus_a.trans     = trans;
    assign bus_a.SHIFT_REG = SHIFT_REG;
    assign bus_s.write     = write;
    assign bus_s.DC        = DC;
    assign bus_s.trans     = trans;
    assign bus_s.SHIFT_REG = SHIFT_REG;

    ram_frame_wr_ctrl #(.LAYERS(LAYERS), .ADDR_W(ADDR_W), .BPP(BPP),
                        .ROW_LEN(8), .SERPENTINE(0)) dut_lin (
        .SCLK  (SCLK),
        .Rst_n (Rst_n),
        .bus   (bus_a.slave)
    );

    ram_frame_wr_ctrl #(.LAYERS(LAYERS), .ADDR_W(ADDR_W), .BPP(BPP),
                        .ROW_LEN(8), .SERPENTINE(1)) dut_serp (
        .SCLK  (SCLK),
        .Rst_n (Rst_n),
        .bus   (bus_s.slave)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    endtask

    function automatic int serp_map(input int p);
        int row, col;
        row = p / 8;
        col = p % 8;
        if (row % 2 == 1) col = 7 - col;
        return row * 8 + col;
    endfunction

    // scoreboard: compare on the falling edge, then advance the model for the next rising edge
    always @(negedge SCLK) begin
        logic [1:0] pend;
        logic [1:0] nxt;
        logic [7:0] e_le;
        logic [3:0] e_be;
        int         pix;
        bit         acc;

        pend = 2'b00;
        if (!Rst_n) begin
            m_mode = M_IDLE;
            m_k    = 0;
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            pend = exp_q.pop_front();
        end

        acc  = Rst_n && write && !trans;
        pix  = (m_mode == M_DATA) ? (m_k / BPP) % NPIX : (m_mode == M_PTR) ? m_k : 0;
        e_le = '0;
        e_be = '0;
        if (acc && DC && m_mode == M_DATA) begin
            e_le = 8'(1 << (m_k / (NPIX * BPP)));
            e_be = 4'(1 << (BPP - 1 - m_k % BPP));
        end else if (acc && DC && m_mode == M_PTR) begin
            e_le = 8'hFF;
            e_be = 4'b1000;
        end

        chk("layer_en",      bus_a.layer_en, e_le);
        chk("byte_en",       bus_a.byte_en,  e_be);
        chk("wraddre",       bus_a.wraddre,  pix);
        chk("serp_wraddre",  bus_s.wraddre,  serp_map(pix));
        chk("serp_layer_en", bus_s.layer_en, e_le);
        chk("read",          bus_a.read,     pend[1]);
        chk("abort",         bus_a.abort,    pend[0]);
        chk("busy",          bus_a.busy,     m_mode != M_IDLE);

        if (acc && DC && m_mode == M_DATA) begin
            case (m_k)
                0: begin
                    chk("lit_byte1_layer", bus_a.layer_en, 8'h01);
                    chk("lit_byte1_lane",  bus_a.byte_en,  4'b0100);
                    chk("lit_byte1_addr",  bus_a.wraddre,  0);
                end
                3:    chk("lit_byte4_addr",   bus_a.wraddre,  1);
                192:  chk("lit_byte193_layer", bus_a.layer_en, 8'h02);
                1535: begin
                    chk("lit_last_layer", bus_a.layer_en, 8'h80);
                    chk("lit_last_lane",  bus_a.byte_en,  4'b0001);
                    chk("lit_last_addr",  bus_a.wraddre,  63);
                end
                default: ;
            endcase
        end
        if (acc && DC && m_mode == M_PTR) begin
            case (m_k)
                8:  chk("lit_serp_px8",  bus_s.wraddre, 15);
                15: chk("lit_serp_px15", bus_s.wraddre, 8);
                16: chk("lit_serp_px16", bus_s.wraddre, 16);
                63: chk("lit_ptr_px63",  bus_a.wraddre, 63);
                default: ;
            endcase
        end

        nxt = 2'b00;
        if (acc && !DC) begin
            nxt[0] = (m_mode != M_IDLE);
            m_mode = (SHIFT_REG == 8'hDA) ? M_DATA : (SHIFT_REG == 8'hCC) ? M_PTR : M_IDLE;
            m_k    = 0;
        end else if (acc && DC && m_mode != M_IDLE) begin
            m_k++;
            if (m_mode == M_DATA && m_k == FRAME) begin
                m_mode = M_IDLE;
                m_k    = 0;
                nxt[1] = 1'b1;
            end else if (m_mode == M_PTR && m_k == NPIX) begin
                m_mode = M_IDLE;
                m_k    = 0;
            end
        end
        if (Rst_n) exp_q.push_back(nxt);
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic strobe(input logic dc, input logic [7:0] b);
        write     = 1'b1;
        DC        = dc;
        SHIFT_REG = b;
        @(posedge SCLK);
        #1;
        write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge SCLK);
            #1;
        end
    endtask

    task automatic send_data(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 15) == 0) begin
                trans = 1'b1;
                strobe(1'b1, 8'($urandom));
                trans = 1'b0;
            end
            strobe(1'b1, 8'($urandom));
        end
    endtask

    initial begin
        Rst_n     = 1'b0;
        write     = 1'b0;
        DC        = 1'b0;
        trans     = 1'b0;
        SHIFT_REG = 8'h00;
        idle(3);
        chk("rst_layer_en", bus_a.layer_en, 0);
        chk("rst_byte_en",  bus_a.byte_en,  0);
        chk("rst_wraddre",  bus_s.wraddre,  0);
        chk("rst_busy",     bus_a.busy,     0);
        chk("rst_read",     bus_a.read,     0);
        Rst_n = 1'b1;
        idle(2);

        // data and unknown commands in IDLE are ignored
        send_data(4);
        strobe(1'b0, 8'h55);
        send_data(3);

        // full data frame
        strobe(1'b0, 8'hDA);
        send_data(FRAME);
        chk("lit_read_pulse", bus_a.read, 1);
        chk("lit_busy_drop",  bus_a.busy, 0);
        idle(1);
        chk("lit_read_single", bus_a.read, 0);
        send_data(5);

        // pointer frame
        strobe(1'b0, 8'hCC);
        send_data(NPIX);
        idle(1);
        chk("lit_ptr_no_read", bus_a.read, 0);
        chk("lit_ptr_idle",    bus_a.busy, 0);

        // abort and restart
        strobe(1'b0, 8'hDA);
        send_data(100);
        strobe(1'b0, 8'hDA);
        chk("lit_abort_pulse", bus_a.abort, 1);
        write     = 1'b1;
        DC        = 1'b1;
        SHIFT_REG = 8'h3C;
        #1;
        chk("lit_restart_layer", bus_a.layer_en, 8'h01);
        chk("lit_restart_addr",  bus_a.wraddre,  0);
        chk("lit_restart_lane",  bus_a.byte_en,  4'b0100);
        @(posedge SCLK);
        #1;
        write = 1'b0;
        chk("lit_abort_single", bus_a.abort, 0);
        send_data(20);
        strobe(1'b0, 8'hCC);
        send_data(30);
        strobe(1'b0, 8'h11);
        send_data(4);

        // reset one byte short of a complete frame
        strobe(1'b0, 8'hDA);
        send_data(FRAME - 1);
        Rst_n = 1'b0;
        #1;
        chk("lit_midrst_busy",  bus_a.busy,    0);
        chk("lit_midrst_addr",  bus_a.wraddre, 0);
        chk("lit_midrst_read",  bus_a.read,    0);
        chk("lit_midrst_abort", bus_a.abort,   0);
        idle(2);
        Rst_n = 1'b1;
        idle(2);
        write     = 1'b1;
        DC        = 1'b1;
        SHIFT_REG = 8'hA5;
        #1;
        chk("lit_postrst_layer", bus_a.layer_en, 0);
        @(posedge SCLK);
        #1;
        write = 1'b0;

        // random mix of commands and data
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       strobe(1'b0, 8'hDA);
                1:       strobe(1'b0, 8'hCC);
                2:       strobe(1'b0, 8'($urandom));
                default: send_data(1);
            endcase
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
